// File: rtl/digital_tube_seg_driver_pkg.sv
// Shared types and constants for the 4-digit tube segment driver.
// Provides the digit/segment typedefs, the hex decode table and the FSM state type.
package digital_tube_seg_driver_pkg;

    localparam int unsigned PARAM_DW_DIGITAL_TUBE      = 4;
    localparam int unsigned PARAM_BLANK_CYCLES_DEFAULT = 8;

    typedef logic [PARAM_DW_DIGITAL_TUBE-1:0] digital_tube_t;
    typedef logic [6:0]                        seg7_t;
    typedef logic [7:0]                        datatype_u8_t;
    typedef logic [15:0]                       datatype_u16_t;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } drv_state_t;

    typedef struct packed {
        datatype_u16_t value;
        digital_tube_t dp;
        logic          blank_lz;
    } disp_word_t;

    // Active-high internal encoding, bit order {g,f,e,d,c,b,a}
    localparam seg7_t SEG_0 = 7'h3F;
    localparam seg7_t SEG_1 = 7'h06;
    localparam seg7_t SEG_2 = 7'h5B;
    localparam seg7_t SEG_3 = 7'h4F;
    localparam seg7_t SEG_4 = 7'h66;
    localparam seg7_t SEG_5 = 7'h6D;
    localparam seg7_t SEG_6 = 7'h7D;
    localparam seg7_t SEG_7 = 7'h07;
    localparam seg7_t SEG_8 = 7'h7F;
    localparam seg7_t SEG_9 = 7'h6F;
    localparam seg7_t SEG_A = 7'h77;
    localparam seg7_t SEG_B = 7'h7C;
    localparam seg7_t SEG_C = 7'h39;
    localparam seg7_t SEG_D = 7'h5E;
    localparam seg7_t SEG_E = 7'h79;
    localparam seg7_t SEG_F = 7'h71;

endpackage

// File: rtl/digital_tube_seg_driver_hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment pattern.
module hex_to_seg7
    import digital_tube_seg_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg7_t      seg_o
);

    always_comb begin
        case (nibble_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            4'hA:    seg_o = SEG_A;
            4'hB:    seg_o = SEG_B;
            4'hC:    seg_o = SEG_C;
            4'hD:    seg_o = SEG_D;
            4'hE:    seg_o = SEG_E;
            default: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/digital_tube_seg_driver.sv
// Tube segment/common driver: frame-aligned value latching, blanking gap on
// every digit switch, leading-zero suppression and pin polarity control.
module digital_tube_seg_driver
    import digital_tube_seg_driver_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES     = PARAM_BLANK_CYCLES_DEFAULT,
    parameter bit          SEG_ACTIVE_LOW   = 1'b1,
    parameter bit          DIGIT_ACTIVE_LOW = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  digital_tube_t digit_en_i,
    input  datatype_u16_t value_i,
    input  digital_tube_t dp_i,
    input  logic          load_i,
    input  logic          blank_lz_i,
    output logic          load_ack_o,
    output digital_tube_t digit_o,
    output seg7_t         seg_o,
    output logic          dp_o,
    output logic          frame_o
);

    localparam datatype_u8_t  BLANK_LOAD = datatype_u8_t'(BLANK_CYCLES);
    localparam seg7_t         SEG_OFF    = {7{SEG_ACTIVE_LOW}};
    localparam digital_tube_t DIGIT_OFF  = {PARAM_DW_DIGITAL_TUBE{DIGIT_ACTIVE_LOW}};
    localparam logic          DP_OFF     = SEG_ACTIVE_LOW;

    drv_state_t    state;
    datatype_u8_t  blank_cnt;
    digital_tube_t en_q;
    disp_word_t    shadow;
    disp_word_t    staging;
    logic          pending;

    logic          change;
    logic          frame_edge;
    logic          en_legal;
    disp_word_t    load_word;
    logic [1:0]    digit_idx;
    logic [3:0]    nibble;
    seg7_t         seg_dec;
    logic          lz_hit;
    seg7_t         seg_drv;
    logic          dp_drv;

    assign change     = (en_q != digit_en_i);
    assign frame_edge = change && (digit_en_i == digital_tube_t'(1));
    assign en_legal   = $onehot(en_q);
    assign load_word  = '{value: value_i, dp: dp_i, blank_lz: blank_lz_i};

    always_comb begin
        digit_idx = '0;
        for (int unsigned i = 0; i < PARAM_DW_DIGITAL_TUBE; i++) begin
            if (en_q[i]) digit_idx = 2'(i);
        end
    end

    assign nibble = shadow.value[{digit_idx, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (nibble),
        .seg_o    (seg_dec)
    );

    // A digit is dark when it and every more-significant nibble are zero
    always_comb begin
        case (digit_idx)
            2'd1:    lz_hit = (shadow.value[15:4]  == '0);
            2'd2:    lz_hit = (shadow.value[15:8]  == '0);
            2'd3:    lz_hit = (shadow.value[15:12] == '0);
            default: lz_hit = 1'b0;
        endcase
        seg_drv = (shadow.blank_lz && lz_hit) ? '0 : seg_dec;
        dp_drv  = shadow.dp[digit_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BLANK;
            blank_cnt  <= '0;
            en_q       <= '0;
            shadow     <= '0;
            staging    <= '0;
            pending    <= 1'b0;
            load_ack_o <= 1'b0;
            frame_o    <= 1'b0;
            digit_o    <= DIGIT_OFF;
            seg_o      <= SEG_OFF;
            dp_o       <= DP_OFF;
        end else begin
            en_q       <= digit_en_i;
            frame_o    <= frame_edge;
            load_ack_o <= 1'b0;

            // A load on the boundary edge itself bypasses staging
            if (frame_edge && (load_i || pending)) begin
                shadow     <= load_i ? load_word : staging;
                pending    <= 1'b0;
                load_ack_o <= 1'b1;
            end else if (load_i) begin
                staging <= load_word;
                pending <= 1'b1;
            end

            digit_o <= DIGIT_OFF;
            seg_o   <= SEG_OFF;
            dp_o    <= DP_OFF;

            if (change) begin
                state     <= ST_BLANK;
                blank_cnt <= BLANK_LOAD;
            end else begin
                case (state)
                    ST_BLANK: begin
                        if (blank_cnt != '0) begin
                            blank_cnt <= blank_cnt - 8'd1;
                        end else if (en_legal) begin
                            state   <= ST_DRIVE;
                            digit_o <= en_q ^ DIGIT_OFF;
                            seg_o   <= seg_drv ^ SEG_OFF;
                            dp_o    <= dp_drv ^ DP_OFF;
                        end
                    end
                    default: begin
                        digit_o <= en_q ^ DIGIT_OFF;
                        seg_o   <= seg_drv ^ SEG_OFF;
                        dp_o    <= dp_drv ^ DP_OFF;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_digital_tube_seg_driver.sv
// Scoreboard bench: three parameter variants share one stimulus stream and one
// behavioural model; the monitor compares every cycle's pin state.
module tb_digital_tube_seg_driver;

    typedef struct packed {
        logic [3:0] digit;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
        logic       ack;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
        obs_t c;
    } trio_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  digit_en = 4'h0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic        load = 1'b0;
    logic        blz = 1'b0;

    logic [3:0] a_digit, b_digit, c_digit;
    logic [6:0] a_seg, b_seg, c_seg;
    logic       a_dp, b_dp, c_dp;
    logic       a_frame, b_frame, c_frame;
    logic       a_ack, b_ack, c_ack;

    int checks = 0;
    int failures = 0;
    bit stim_done = 1'b0;

    trio_t exp_q[$];

    initial forever #5 clk = ~clk;

    digital_tube_seg_driver #(.BLANK_CYCLES(8), .SEG_ACTIVE_LOW(1'b0), .DIGIT_ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst(rst), .digit_en_i(digit_en), .value_i(value), .dp_i(dp), .load_i(load),
        .blank_lz_i(blz), .load_ack_o(a_ack), .digit_o(a_digit), .seg_o(a_seg), .dp_o(a_dp), .frame_o(a_frame));

    digital_tube_seg_driver #(.BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst(rst), .digit_en_i(digit_en), .value_i(value), .dp_i(dp), .load_i(load),
        .blank_lz_i(blz), .load_ack_o(b_ack), .digit_o(b_digit), .seg_o(b_seg), .dp_o(b_dp), .frame_o(b_frame));

    digital_tube_seg_driver #(.BLANK_CYCLES(3), .SEG_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b1)) dut_c (
        .clk(clk), .rst(rst), .digit_en_i(digit_en), .value_i(value), .dp_i(dp), .load_i(load),
        .blank_lz_i(blz), .load_ack_o(c_ack), .digit_o(c_digit), .seg_o(c_seg), .dp_o(c_dp), .frame_o(c_frame));

    // Reference model state
    logic [6:0]  tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0]  m_en = 4'h0;
    int          m_since = 0;
    logic [15:0] m_val = 16'h0;
    logic [3:0]  m_dp = 4'h0;
    logic        m_blz = 1'b0;
    logic [15:0] s_val = 16'h0;
    logic [3:0]  s_dp = 4'h0;
    logic        s_blz = 1'b0;
    logic        m_pend = 1'b0;

    function automatic obs_t expect_out(int b, bit sal, bit dal, bit fr, bit ak);
        obs_t        o;
        int          k;
        logic [15:0] upper;
        o = '0;
        o.frame = fr;
        o.ack   = ak;
        if (m_since >= b + 1 && $countones(m_en) == 1) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (m_en[i]) k = i;
            upper   = m_val >> (4 * k);
            o.digit = m_en;
            o.seg   = tbl[upper[3:0]];
            if (m_blz && k > 0 && upper == 16'h0) o.seg = 7'h00;
            o.dp    = m_dp[k];
        end
        if (dal) o.digit = ~o.digit;
        if (sal) begin
            o.seg = ~o.seg;
            o.dp  = ~o.dp;
        end
        return o;
    endfunction

    task automatic cycle(input logic r, input logic [3:0] en, input logic [15:0] v,
                         input logic [3:0] d, input logic ld, input logic bz);
        bit    chg, fr, ak;
        trio_t e;
        rst = r; digit_en = en; value = v; dp = d; load = ld; blz = bz;
        @(posedge clk);
        fr = 1'b0;
        ak = 1'b0;
        if (r) begin
            m_en = 4'h0; m_since = 0; m_val = 16'h0; m_dp = 4'h0; m_blz = 1'b0; m_pend = 1'b0;
        end else begin
            chg = (en != m_en);
            fr  = chg && (en == 4'b0001);
            if (fr && (ld || m_pend)) begin
                if (ld) begin
                    m_val = v; m_dp = d; m_blz = bz;
                end else begin
                    m_val = s_val; m_dp = s_dp; m_blz = s_blz;
                end
                m_pend = 1'b0;
                ak = 1'b1;
            end else if (ld) begin
                s_val = v; s_dp = d; s_blz = bz; m_pend = 1'b1;
            end
            if (chg) begin
                m_en = en;
                m_since = 0;
            end else if (m_since < 1000) begin
                m_since++;
            end
        end
        e.a = expect_out(8, 1'b0, 1'b0, fr, ak);
        e.b = expect_out(0, 1'b1, 1'b0, fr, ak);
        e.c = expect_out(3, 1'b1, 1'b1, fr, ak);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic hold(input logic [3:0] en, input int n, input logic bz);
        for (int i = 0; i < n; i++) cycle(1'b0, en, 16'($urandom), 4'($urandom), 1'b0, bz);
    endtask

    task automatic scan_round(input int n);
        hold(4'b0001, n, 1'b0);
        hold(4'b0010, n, 1'b0);
        hold(4'b0100, n, 1'b0);
        hold(4'b1000, n, 1'b0);
    endtask

    task automatic check_one(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got digit=%h seg=%h dp=%b frame=%b ack=%b, expected digit=%h seg=%h dp=%b frame=%b ack=%b",
                     name, $time, act.digit, act.seg, act.dp, act.frame, act.ack,
                     exp.digit, exp.seg, exp.dp, exp.frame, exp.ack);
        end
    endtask

    // Monitor: outputs are stable at the falling edge after each sampled edge
    initial begin
        trio_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_one("dut_a", {a_digit, a_seg, a_dp, a_frame, a_ack}, e.a);
                check_one("dut_b", {b_digit, b_seg, b_dp, b_frame, b_ack}, e.b);
                check_one("dut_c", {c_digit, c_seg, c_dp, c_frame, c_ack}, e.c);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: stimulus did not complete, required completion before %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [3:0] en;
        logic [3:0] scan_en;
        int         dur;
        int         r;

        cycle(1'b1, 4'h0, 16'h0, 4'h0, 1'b0, 1'b0);
        cycle(1'b1, 4'h0, 16'h0, 4'h0, 1'b0, 1'b0);
        hold(4'h0, 5, 1'b0);

        // Basic scan of 1A3F
        cycle(1'b0, 4'h0, 16'h1A3F, 4'h0, 1'b1, 1'b0);
        scan_round(100);
        scan_round(100);

        // Tear-free: load 8888 mid-frame while digit 2 is lit
        hold(4'b0001, 100, 1'b0);
        hold(4'b0010, 100, 1'b0);
        hold(4'b0100, 50, 1'b0);
        cycle(1'b0, 4'b0100, 16'h8888, 4'h0, 1'b1, 1'b0);
        hold(4'b0100, 49, 1'b0);
        hold(4'b1000, 100, 1'b0);
        scan_round(100);

        // Load coinciding with the frame boundary edge
        cycle(1'b0, 4'b0001, 16'h2B7C, 4'b0101, 1'b1, 1'b0);
        hold(4'b0001, 30, 1'b0);
        hold(4'b0010, 30, 1'b0);
        hold(4'b0100, 30, 1'b0);
        hold(4'b1000, 30, 1'b0);

        // Leading-zero suppression, then an all-zero value
        cycle(1'b0, 4'b1000, 16'h0050, 4'b1000, 1'b1, 1'b1);
        hold(4'b1000, 10, 1'b1);
        scan_round(20);
        cycle(1'b0, 4'b1000, 16'h0000, 4'b0000, 1'b1, 1'b1);
        hold(4'b1000, 10, 1'b1);
        scan_round(20);

        // Illegal enables and over-short slots
        hold(4'b0000, 20, 1'b0);
        hold(4'b0011, 20, 1'b0);
        hold(4'b0001, 20, 1'b0);
        for (int i = 0; i < 16; i++) hold(4'b0001 << (i % 4), 4, 1'b0);
        scan_round(15);

        // Reset with a load pending before the frame boundary
        cycle(1'b0, 4'b0010, 16'hFEDC, 4'hF, 1'b1, 1'b0);
        hold(4'b0010, 10, 1'b0);
        hold(4'b0100, 10, 1'b0);
        cycle(1'b1, 4'b0100, 16'h0, 4'h0, 1'b0, 1'b0);
        hold(4'b1000, 20, 1'b0);
        scan_round(20);

        // Randomized traffic
        scan_en = 4'b0001;
        for (int s = 0; s < 150; s++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                scan_en = {scan_en[2:0], scan_en[3]};
                en = scan_en;
            end else if (r == 7) begin
                en = 4'($urandom);
            end else begin
                en = 4'b0001 << $urandom_range(0, 3);
            end
            dur = $urandom_range(1, 30);
            for (int i = 0; i < dur; i++) begin
                cycle(($urandom_range(0, 599) == 0), en, 16'($urandom), 4'($urandom),
                      ($urandom_range(0, 24) == 0), 1'($urandom));
            end
        end

        stim_done = 1'b1;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
